uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter that drains the debug unit's byte-wide TX interface (tx_data / tx_start / tx_done) onto the host-facing serial line.
- Sits beside the debug unit in the debug top, facing the UART receiver that feeds it rx_data / rx_done.
- Frame format: 8N1 by default, with optional even/odd parity.
- Bit timing comes from an external oversampling tick shared with the receiver.

Parameters:
- NB_DATA, 8, data bits per frame, sent LSB first.
- TICKS_PER_BIT, 16, i_tick pulses per start/data/parity bit.
- SB_TICK, 16, i_tick pulses in the stop period (16 = 1 stop bit, 32 = 2 stop bits).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- i_clock  in  1  system clock (clk_wiz domain).
- i_reset  in  1  synchronous, active-low reset.
- i_tick  in  1  oversampling tick, one-cycle pulse, TICKS_PER_BIT per bit time.
- i_tx_start  in  1  start request, sampled only in IDLE.
- i_tx_data  in  NB_DATA  byte to send, captured on an accepted start.
- o_tx  out  1  serial line, idle high.
- o_tx_done  out  1  one-cycle pulse when the frame, including stop, completes.
- o_tx_busy  out  1  high from the accept cycle until the done pulse.

Behaviour:
- Clock and reset: one clock, i_clock. i_reset is synchronous and active-low; it is sampled on the i_clock rising edge and is low to reset.
- Reset values: state = IDLE, o_tx = 1, o_tx_done = 0, o_tx_busy = 0, tick count = 0, bit index = 0, shift register = 0.
- Reset mid-frame aborts the frame immediately: the line returns high on the next cycle and no done pulse is produced.
- States: IDLE, START, DATA, PAR, STOP. Encodings come from the package; all outputs are registered.
- IDLE:
  - If i_tx_start = 1 at an edge: latch i_tx_data into the shift register, clear tick count and bit index, go to START.
  - From the next cycle, o_tx = 0 and o_tx_busy = 1. Latency start to line low = 1 cycle.
  - i_tx_start while not in IDLE is ignored; there is no queueing.
- Tick counting (START, DATA, PAR):
  - The count advances only on cycles with i_tick = 1.
  - When i_tick = 1 and count = TICKS_PER_BIT-1: clear the count and advance the bit.
  - With no ticks the FSM holds indefinitely.
- START: o_tx = 0 for TICKS_PER_BIT ticks, then go to DATA.
- DATA:
  - o_tx = shift[0].
  - At each bit end, shift right and increment the bit index.
  - After bit NB_DATA-1, go to PAR if PARITY != 0, else go to STOP.
- PAR:
  - o_tx = XOR of the latched byte for even parity, its inverse for odd.
  - The parity is computed at latch time and stored, never from the shifted register.
  - Lasts TICKS_PER_BIT ticks, then go to STOP.
- STOP:
  - o_tx = 1 for SB_TICK ticks.
  - On the last tick: go to IDLE, o_tx_done = 1 for exactly one cycle (the first IDLE cycle), o_tx_busy = 0 in that same cycle.
- Back-to-back: i_tx_start asserted in the cycle where o_tx_done = 1 is accepted, since the FSM is already in IDLE. The line stays high for at most 1 cycle between frames.
- Frame length (PARITY = 0, defaults): 10 bit times = 160 ticks from the START entry to the done pulse.
- Illegal state encoding: recover to IDLE with the line high.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (3 bits);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - default NB_DATA and TICKS_PER_BIT, shared with the receiver.
- No sub-module: uart_tx is a single FSM plus datapath.
- The tick source (baud_rate_gen) is a separate, existing-style module instantiated at the top and shared with the receiver.

Test Plan:
- Reset, then i_tick every cycle and i_tx_start with 0xA5 (PARITY = 0). Required response:
  - o_tx sequence, 16 cycles per bit: 0, 1, 0, 1, 0, 0, 1, 0, 1, 1;
  - o_tx_done pulses exactly 160 cycles after the line first goes low;
  - o_tx_busy is high for exactly that window.
- PARITY = 1 then 2, send 0xA5 (four ones) and 0x07 (three ones). Required parity bit: even gives 0 and 1 respectively; odd gives 1 and 0.
- i_tick every 4th cycle. Required response: each bit lasts 64 cycles; the FSM freezes when i_tick is held low for 100 cycles mid-DATA, and o_tx does not change during the freeze.
- Pulse i_tx_start with 0x3C mid-frame, then again in the done cycle with 0x81. Required response:
  - the mid-frame request is ignored;
  - 0x81 starts with a 1-cycle gap and is transmitted intact.
- Assert i_reset = 0 for one cycle during DATA bit 3. Required response:
  - o_tx = 1 and o_tx_busy = 0 on the next cycle;
  - no o_tx_done;
  - a following start with 0x55 transmits a clean frame.
- SB_TICK = 32. Required response: the stop period is 32 ticks, and done is asserted after 176 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (FSM encodings, parity modes, frame defaults) for the TX and RX sides.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;
    localparam int PAR_NONE          = 0;
    localparam int PAR_EVEN          = 1;
    localparam int PAR_ODD           = 2;
    localparam int NB_DATA_DEF       = 8;
    localparam int TICKS_PER_BIT_DEF = 16;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: tick-paced serial transmitter, start + NB_DATA bits LSB first + optional parity + stop.
// Ports: i_clock system clock; i_reset sync active-low reset; i_tick oversampling pulse;
//        i_tx_start/i_tx_data byte request (taken only when idle); o_tx serial line (idle high);
//        o_tx_done one-cycle end-of-frame pulse; o_tx_busy high from accept until done.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA       = NB_DATA_DEF,
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int SB_TICK       = 16,
    parameter int PARITY        = PAR_NONE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_tx_busy
);
    localparam int CNT_MAX = (TICKS_PER_BIT > SB_TICK) ? TICKS_PER_BIT : SB_TICK;
    localparam int TW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(NB_DATA - 1);
    localparam logic HAS_PAR = (PARITY != PAR_NONE);
    localparam logic PAR_INV = (PARITY == PAR_ODD);

    state_t             r_state, w_state;
    logic [TW-1:0]      r_tick, w_tick;
    logic [BW-1:0]      r_bit, w_bit;
    logic [NB_DATA-1:0] r_shift, w_shift;
    logic               r_par, w_par;
    logic               r_tx, w_tx;
    logic               r_done, w_done;
    logic               r_busy, w_busy;
    logic               w_bit_end, w_stop_end;
    logic [TW-1:0]      w_tick_inc;

    assign w_bit_end  = i_tick && (r_tick == BIT_LAST);
    assign w_stop_end = i_tick && (r_tick == STOP_LAST);
    assign w_tick_inc = i_tick ? r_tick + TW'(1) : r_tick;

    // Line value is decided one cycle ahead so every output leaves a flop.
    always_comb begin
        w_state = r_state;
        w_tick  = w_tick_inc;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_par   = r_par;
        w_tx    = r_tx;
        w_done  = 1'b0;
        w_busy  = r_busy;
        case (r_state)
            ST_IDLE: begin
                w_tick = '0;
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (i_tx_start) begin
                    w_state = ST_START;
                    w_shift = i_tx_data;
                    w_bit   = '0;
                    // Parity taken from the unshifted byte at accept time.
                    w_par   = (^i_tx_data) ^ PAR_INV;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            ST_START: if (w_bit_end) begin
                w_state = ST_DATA;
                w_tick  = '0;
                w_tx    = r_shift[0];
            end
            ST_DATA: if (w_bit_end) begin
                w_tick  = '0;
                w_shift = r_shift >> 1;
                if (r_bit == IDX_LAST) begin
                    w_state = HAS_PAR ? ST_PAR : ST_STOP;
                    w_tx    = HAS_PAR ? r_par : 1'b1;
                end else begin
                    w_bit = r_bit + BW'(1);
                    w_tx  = r_shift[1];
                end
            end
            ST_PAR: if (w_bit_end) begin
                w_state = ST_STOP;
                w_tick  = '0;
                w_tx    = 1'b1;
            end
            ST_STOP: if (w_stop_end) begin
                w_state = ST_IDLE;
                w_tick  = '0;
                w_tx    = 1'b1;
                w_done  = 1'b1;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = ST_IDLE;
                w_tick  = '0;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_tx    <= w_tx;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_done = r_done;
    assign o_tx_busy = r_busy;
endmodule
